// File: rtl/ula_arbiter_if.sv
// Bundle of the two requester channels, the response channel and the shared ULA port.
// The arbiter takes the slave view; the requesters, consumer and ULA take the master view.
interface ula_arbiter_if;
  logic        req0_valid, req0_ready;
  logic [7:0]  req0_a, req0_b;
  logic [3:0]  req0_op;
  logic        req1_valid, req1_ready;
  logic [7:0]  req1_a, req1_b;
  logic [3:0]  req1_op;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [15:0] rsp_result;
  logic        rsp_zero, rsp_sign, rsp_illegal;
  logic [7:0]  ula_a, ula_b;
  logic [3:0]  ula_sel;
  logic [15:0] ula_result;
  logic        ula_zero, ula_sign;
  logic        busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  rsp_ready, ula_result, ula_zero, ula_sign,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_sign, rsp_illegal,
    output ula_a, ula_b, ula_sel, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output rsp_ready, ula_result, ula_zero, ula_sign,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_sign, rsp_illegal,
    input  ula_a, ula_b, ula_sel, busy
  );
endinterface

// File: rtl/ula_arbiter.sv
// Two-requester round-robin arbiter in front of a shared multi-cycle ULA.
// One operation in flight at a time: grant, hold operands for EXEC_CYCLES, capture, respond.
module ula_arbiter #(
  parameter int EXEC_CYCLES = 1
) (
  input  logic         clk,
  input  logic         rst,
  ula_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam logic [3:0] LAST = 4'(EXEC_CYCLES - 1);

  state_t      state;
  logic        ptr;
  logic [3:0]  cnt;
  logic        cur_id;
  logic        rsp_valid_q, rsp_id_q, rsp_zero_q, rsp_sign_q, rsp_illegal_q;
  logic [15:0] rsp_result_q;
  logic [7:0]  ula_a_q, ula_b_q;
  logic [3:0]  ula_sel_q;

  logic [1:0]       vld;
  logic [1:0][7:0]  a_in, b_in;
  logic [1:0][3:0]  op_in;
  logic [1:0]       rdy;
  logic             gnt_id;

  assign vld   = {bus.req1_valid, bus.req0_valid};
  assign a_in  = {bus.req1_a,  bus.req0_a};
  assign b_in  = {bus.req1_b,  bus.req0_b};
  assign op_in = {bus.req1_op, bus.req0_op};

  // Pointer only matters on contention; a lone requester always wins.
  assign gnt_id = (&vld) ? ptr : vld[1];

  always_comb begin
    rdy = '0;
    if (!rst && state == IDLE && |vld) rdy[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= 1'b0;
      cnt           <= '0;
      cur_id        <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_id_q      <= 1'b0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_sign_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
      ula_a_q       <= '0;
      ula_b_q       <= '0;
      ula_sel_q     <= '0;
    end else begin
      case (state)
        IDLE: if (|vld) begin
          ula_a_q   <= a_in[gnt_id];
          ula_b_q   <= b_in[gnt_id];
          ula_sel_q <= op_in[gnt_id];
          ptr       <= ~gnt_id;
          cur_id    <= gnt_id;
          // Codes 12..15 have no ULA function: answer immediately without executing.
          if (op_in[gnt_id] >= 4'd12) begin
            rsp_valid_q   <= 1'b1;
            rsp_id_q      <= gnt_id;
            rsp_result_q  <= '0;
            rsp_zero_q    <= 1'b0;
            rsp_sign_q    <= 1'b0;
            rsp_illegal_q <= 1'b1;
            state         <= RESP;
          end else begin
            cnt   <= '0;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == LAST) begin
            rsp_valid_q   <= 1'b1;
            rsp_id_q      <= cur_id;
            rsp_result_q  <= bus.ula_result;
            rsp_zero_q    <= bus.ula_zero;
            rsp_sign_q    <= bus.ula_sign;
            rsp_illegal_q <= 1'b0;
            cnt           <= '0;
            state         <= RESP;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        RESP: if (bus.rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req0_ready  = rdy[0];
  assign bus.req1_ready  = rdy[1];
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_id      = rsp_id_q;
  assign bus.rsp_result  = rsp_result_q;
  assign bus.rsp_zero    = rsp_zero_q;
  assign bus.rsp_sign    = rsp_sign_q;
  assign bus.rsp_illegal = rsp_illegal_q;
  assign bus.ula_a       = ula_a_q;
  assign bus.ula_b       = ula_b_q;
  assign bus.ula_sel     = ula_sel_q;
  assign bus.busy        = (state != IDLE);
endmodule
